// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Round-robin arbiter and burst sequencer sharing one main
//                memory port between the I-cache refill port and the D-cache
//                refill/write-back port. Each granted line transfer is issued
//                as LINE_WORDS single-word beats, followed by a one-cycle
//                completion pulse to the owning requester.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst,

    // Instruction-cache refill port
    input  logic                          i_req,
    input  logic                          i_we,
    input  logic [ADDR_WIDTH-1:0]         i_addr,
    input  logic [DATA_WIDTH-1:0]         i_wdata,
    output logic                          i_rvalid,
    output logic                          i_done,

    // Data-cache refill / write-back port
    input  logic                          d_req,
    input  logic                          d_we,
    input  logic [ADDR_WIDTH-1:0]         d_addr,
    input  logic [DATA_WIDTH-1:0]         d_wdata,
    output logic                          d_rvalid,
    output logic                          d_done,

    // Shared read return and transfer status
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic [$clog2(LINE_WORDS)-1:0] beat,
    output logic                          busy,

    // Backing memory port
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic                          mem_ready,
    input  logic [DATA_WIDTH-1:0]         mem_rdata
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Beat index width and the number of byte-offset bits below a line base.
    localparam int c_BEAT_W = $clog2(LINE_WORDS);
    localparam int c_OFF    = c_BEAT_W + 2;
    localparam int c_BASE_W = ADDR_WIDTH - c_OFF;

    localparam logic [c_BEAT_W-1:0] c_BEAT_ZERO = '0;
    localparam logic [c_BEAT_W-1:0] c_BEAT_ONE  = c_BEAT_W'(1);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(LINE_WORDS - 1);

    // Requester identities as stored in the owner / last-grant registers.
    localparam logic c_OWNER_I = 1'b0;
    localparam logic c_OWNER_D = 1'b1;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic                r_owner;       // requester owning the current transfer
    logic                r_last_grant;  // most recent winner, for tie-breaking
    logic                r_we;          // latched transfer direction
    logic [c_BASE_W-1:0] r_base;        // latched line base (word offset dropped)
    logic [c_BEAT_W-1:0] r_beat;        // beat index within the line

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                w_any_req;
    logic                w_winner;
    logic                w_win_we;
    logic [c_BASE_W-1:0] w_win_base;
    logic                w_in_burst;
    logic                w_in_done;
    logic                w_beat_fire;
    logic                w_last_beat;
    logic                w_rd_fire;

    // The low line-offset bits of the request addresses carry no meaning:
    // the transfer always starts at the line base.
    logic                w_unused_addr_bits;
    assign w_unused_addr_bits = &{1'b0, i_addr[c_OFF-1:0], d_addr[c_OFF-1:0]};

    // Arbitration: a lone requester wins outright; on a tie the requester
    // that did not win last time gets the grant.
    always_comb begin
        w_any_req  = i_req | d_req;
        w_winner   = c_OWNER_I;
        if (i_req && d_req) begin
            w_winner = ~r_last_grant;
        end else if (d_req) begin
            w_winner = c_OWNER_D;
        end
        w_win_we   = (w_winner == c_OWNER_D) ? d_we : i_we;
        w_win_base = (w_winner == c_OWNER_D) ? d_addr[ADDR_WIDTH-1:c_OFF]
                                             : i_addr[ADDR_WIDTH-1:c_OFF];
    end

    // Beat progress decode for the sequencer and the response strobes.
    always_comb begin
        w_in_burst  = (r_state == ST_BURST);
        w_in_done   = (r_state == ST_DONE);
        w_beat_fire = w_in_burst & mem_ready;
        w_last_beat = (r_beat == c_LAST_BEAT);
        w_rd_fire   = w_beat_fire & ~r_we;
    end

    // ------------------------------------------------------------------------
    // Sequencer: grant in IDLE, step beats on mem_ready in BURST, then a
    // single DONE cycle. Reset aborts any transfer without a completion.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= c_OWNER_I;
            r_last_grant <= c_OWNER_I;
            r_we         <= 1'b0;
            r_base       <= '0;
            r_beat       <= c_BEAT_ZERO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner      <= w_winner;
                        r_last_grant <= w_winner;
                        r_we         <= w_win_we;
                        r_base       <= w_win_base;
                        r_beat       <= c_BEAT_ZERO;
                        r_state      <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    // A stalled beat leaves every memory-side output unchanged.
                    if (mem_ready) begin
                        if (w_last_beat) begin
                            r_beat  <= c_BEAT_ZERO;
                            r_state <= ST_DONE;
                        end else begin
                            r_beat  <= r_beat + c_BEAT_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Memory port: driven only during BURST so the port reads as all-zero
    // whenever no beat is being presented, including right after reset.
    // ------------------------------------------------------------------------
    always_comb begin
        mem_req   = w_in_burst;
        mem_we    = w_in_burst & r_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_in_burst) begin
            mem_addr  = {r_base, r_beat, 2'b00};
            mem_wdata = (r_owner == c_OWNER_D) ? d_wdata : i_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Requester responses: read strobes and completion pulses go only to the
    // current owner; read data is passed through with no added latency.
    // ------------------------------------------------------------------------
    always_comb begin
        i_rvalid = w_rd_fire & (r_owner == c_OWNER_I);
        d_rvalid = w_rd_fire & (r_owner == c_OWNER_D);
        i_done   = w_in_done & (r_owner == c_OWNER_I);
        d_done   = w_in_done & (r_owner == c_OWNER_D);
        rdata    = mem_rdata;
        beat     = r_beat;
        busy     = (r_state != ST_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. A transaction-level
//                reference predicts grants and beat progress; expected read
//                returns, write beats and completions are queued at grant and
//                consumed by a monitor whenever the DUT presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;
    localparam int BW = 2;
    localparam int TIMEOUT = 400;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0, i_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [DW-1:0] i_wdata, d_wdata;
    logic          i_rvalid, i_done, d_rvalid, d_done;
    logic [DW-1:0] rdata;
    logic [BW-1:0] beat;
    logic          busy, mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] mem_rdata;
    bit            rand_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rvalid(i_rvalid), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rvalid(d_rvalid), .d_done(d_done),
        .rdata(rdata), .beat(beat), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & ~32'(LW * 4 - 1);
    endfunction

    // Write word a requester supplies for a given line and beat.
    function automatic logic [31:0] wfun(input bit p, input logic [31:0] base,
                                         input logic [BW-1:0] k);
        return {(p ? 4'hD : 4'h1), base[19:0], 8'hA0 + 8'(k)};
    endfunction

    // Memory content: a fixed hash of the word address.
    function automatic logic [31:0] rfun(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign i_wdata   = wfun(1'b0, line_of(i_addr), beat);
    assign d_wdata   = wfun(1'b1, line_of(d_addr), beat);
    assign mem_rdata = rfun(mem_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_phase = 0;   // 0 idle, 1 transferring beats, 2 completion
    bit          m_owner = 1'b0;
    bit          m_last  = 1'b0; // 0 = I, 1 = D
    bit          m_we    = 1'b0;
    logic [31:0] m_base  = '0;
    int          m_cnt   = 0;
    logic [63:0] q_rd_i[$];
    logic [63:0] q_rd_d[$];
    logic [63:0] q_wr[$];
    bit          q_done[$];

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_last = 1'b0; m_cnt = 0;
            q_rd_i.delete(); q_rd_d.delete(); q_wr.delete(); q_done.delete();
        end else begin
            case (m_phase)
                0: if (i_req || d_req) begin
                    m_owner = (i_req && d_req) ? ~m_last : d_req;
                    m_last  = m_owner;
                    m_we    = m_owner ? d_we : i_we;
                    m_base  = line_of(m_owner ? d_addr : i_addr);
                    m_cnt   = 0;
                    m_phase = 1;
                    for (int k = 0; k < LW; k++) begin
                        if (m_we)
                            q_wr.push_back({m_base + 32'(4 * k), wfun(m_owner, m_base, BW'(k))});
                        else if (m_owner)
                            q_rd_d.push_back({32'(k), rfun(m_base + 32'(4 * k))});
                        else
                            q_rd_i.push_back({32'(k), rfun(m_base + 32'(4 * k))});
                    end
                    q_done.push_back(m_owner);
                end
                1: if (mem_ready) begin
                    m_cnt++;
                    if (m_cnt == LW) begin m_cnt = 0; m_phase = 2; end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst) begin
            check("reset_ctrl", {busy, mem_req, mem_we, beat, i_rvalid, d_rvalid, i_done, d_done}, 0);
            check("reset_mem", {mem_addr, mem_wdata}, 0);
        end else begin
            check("busy", busy, m_phase != 0);
            check("mem_req", mem_req, m_phase == 1);
            if (m_phase == 1) begin
                check("beat", beat, m_cnt);
                check("mem_addr", mem_addr, m_base + 32'(4 * m_cnt));
                check("mem_we", mem_we, m_we);
            end
            check("i_rvalid", i_rvalid, m_phase == 1 && !m_owner && !m_we && mem_ready);
            check("d_rvalid", d_rvalid, m_phase == 1 &&  m_owner && !m_we && mem_ready);
            check("i_done", i_done, m_phase == 2 && !m_owner);
            check("d_done", d_done, m_phase == 2 &&  m_owner);
            if (i_rvalid) begin
                if (q_rd_i.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL i_read_unexpected: got rdata %h, expected no read", rdata);
                end else begin
                    e = q_rd_i.pop_front();
                    check("i_read_data", {32'(beat), rdata}, e);
                end
            end
            if (d_rvalid) begin
                if (q_rd_d.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL d_read_unexpected: got rdata %h, expected no read", rdata);
                end else begin
                    e = q_rd_d.pop_front();
                    check("d_read_data", {32'(beat), rdata}, e);
                end
            end
            if (mem_req && mem_ready && mem_we) begin
                if (q_wr.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL write_unexpected: got addr %h data %h, expected none", mem_addr, mem_wdata);
                end else begin
                    e = q_wr.pop_front();
                    check("write_beat", {mem_addr, mem_wdata}, e);
                end
            end
            if (i_done || d_done) begin
                if (q_done.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL done_unexpected: got i_done=%b d_done=%b, expected none", i_done, d_done);
                end else begin
                    check("done_owner", {i_done, d_done}, q_done.pop_front() ? 2'b01 : 2'b10);
                end
            end
        end
    end

    // Random memory back-pressure when enabled.
    initial forever begin
        @(posedge clk); #1;
        if (rand_ready) mem_ready = ($urandom_range(0, 3) != 0);
    end

    // Counts negedges from the call until the port's done is seen.
    task automatic wait_done(input bit p, output int n);
        bit seen = 1'b0;
        n = 0;
        while (!seen && n < TIMEOUT) begin
            @(negedge clk);
            n++;
            seen = p ? d_done : i_done;
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout port=%0d: no done after %0d cycles, required within %0d", p, n, TIMEOUT);
        end
    endtask

    // Raises a request (caller is just after a clock edge), waits for done,
    // and drops the request on the DONE->IDLE edge.
    task automatic do_xfer(input bit p, input bit we, input logic [31:0] a, output int n);
        if (p) begin d_we = we; d_addr = a; d_req = 1'b1; end
        else   begin i_we = we; i_addr = a; i_req = 1'b1; end
        wait_done(p, n);
        @(posedge clk); #1;
        if (p) d_req = 1'b0; else i_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // ---------------- directed then random stimulus ----------------
    initial begin
        int  n, n1, n2;
        bit  hit;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset during beat 2 of a D read: immediate quiet outputs, no done.
        mem_ready = 1'b1;
        d_we = 1'b0; d_addr = 32'h3000; d_req = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clk);
            hit = busy && beat == 2;
        end
        check("reached_beat2", hit, 1'b1);
        #2 rst = 1'b1;
        #1 check("async_reset", {mem_req, busy, beat}, 0);
        @(posedge clk); #1 d_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        do_xfer(1'b1, 1'b0, 32'h3000, n);
        check("restart_latency", n, 6);

        // Single I read with unaligned base, then a D line write.
        do_xfer(1'b0, 1'b0, 32'h1004, n);
        check("i_read_latency", n, 6);
        do_xfer(1'b1, 1'b1, 32'h2000, n);
        check("d_write_latency", n, 6);

        // Ties after reset: D first, I right after, then D wins the next tie.
        do_reset();
        fork
            do_xfer(1'b0, 1'b0, 32'h6000, n1);
            do_xfer(1'b1, 1'b0, 32'h7000, n2);
        join
        check("tie1_d_first", n2, 6);
        check("tie1_i_next", n1, 12);
        fork
            do_xfer(1'b0, 1'b1, 32'h6010, n1);
            do_xfer(1'b1, 1'b1, 32'h7010, n2);
        join
        check("tie2_d_first", n2, 6);
        check("tie2_i_next", n1, 12);

        // Three wait cycles at beat 1 delay completion by exactly three.
        fork
            do_xfer(1'b0, 1'b0, 32'h8000, n1);
            begin
                mem_ready = 1'b1;
                @(posedge clk); #1 mem_ready = 1'b1;
                @(posedge clk); #1 mem_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 mem_ready = 1'b1;
            end
        join
        check("stall_latency", n1, 9);

        // D held through DONE starts a second transfer from IDLE.
        d_we = 1'b0; d_addr = 32'h9000; d_req = 1'b1;
        wait_done(1'b1, n);
        check("held_first", n, 6);
        @(posedge clk);
        wait_done(1'b1, n);
        check("held_restart", n, 6);
        @(posedge clk); #1 d_req = 1'b0;

        // With D held and I pending at IDLE, I wins since D won last.
        d_addr = 32'hA000; d_req = 1'b1;
        @(posedge clk); #1 i_we = 1'b1; i_addr = 32'hB000; i_req = 1'b1;
        wait_done(1'b1, n);
        @(posedge clk);
        wait_done(1'b0, n);
        check("pending_i_wins", n, 6);
        @(posedge clk); #1 i_req = 1'b0;
        wait_done(1'b1, n);
        check("d_after_i", n, 6);
        @(posedge clk); #1 d_req = 1'b0;

        // Random traffic from both ports with random back-pressure.
        rand_ready = 1'b1;
        fork
            for (int t = 0; t < 12; t++) begin
                int nn;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1 do_xfer(1'b0, 1'($urandom_range(0, 1)), $urandom(), nn);
            end
            for (int t = 0; t < 12; t++) begin
                int nn;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1 do_xfer(1'b1, 1'($urandom_range(0, 1)), $urandom(), nn);
            end
        join
        rand_ready = 1'b0;
        repeat (5) @(posedge clk);
        check("drain_done", q_done.size(), 0);
        check("drain_reads", q_rd_i.size() + q_rd_d.size(), 0);
        check("drain_writes", q_wr.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
